fifo_param: RTL and testbench

Parametrised synchronous FIFO, successor to the fixed 6-bit channel FIFO. It provides configurable data width and depth, and takes almost-empty/almost-full thresholds as runtime inputs. It exposes occupancy and separate overflow/underflow error flags. Storage is an internal register array, with no external memory instance. It sits between a producer and consumer in one clock domain, and its almost flags drive the upstream flow-control logic.

---
 rtl/fifo_param.sv | 102 ++++++++++
 tb/tb_fifo_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with runtime almost-empty/almost-full thresholds,
// occupancy output and overflow/underflow flags. Optional macro FIFO_ERR_STICKY_EN latches the error flags.
module fifo_param #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
   input  logic                  Fifo_wr,
   input  logic                  Fifo_rd,
   input  logic [ADDR_WIDTH:0]   umbral_vacio,
   input  logic [ADDR_WIDTH:0]   umbral_lleno,
   output logic [DATA_WIDTH-1:0] Fifo_data_out,
   output logic                  Fifo_valid,
   output logic                  Fifo_empty,
   output logic                  Fifo_full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int DEPTH_INT = 2 ** ADDR_WIDTH;
   localparam logic [CW-1:0] DEPTH = CW'(DEPTH_INT);

   logic [DATA_WIDTH-1:0] mem [DEPTH_INT];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         next_count;
   logic                  rd_ok;
   logic                  wr_ok;
   logic                  ovf;
   logic                  unf;
   logic                  ovf_next;
   logic                  unf_next;

   // A full FIFO still takes a write when a read frees a slot on the same edge;
   // an empty FIFO never passes a word straight through.
   always_comb begin
      rd_ok      = Fifo_rd && (count != '0);
      wr_ok      = Fifo_wr && ((count != DEPTH) || rd_ok);
      ovf        = Fifo_wr && !wr_ok;
      unf        = Fifo_rd && !rd_ok;
      next_count = count;
      if (wr_ok && !rd_ok)
         next_count = count + CW'(1);
      else if (rd_ok && !wr_ok)
         next_count = count - CW'(1);
`ifdef FIFO_ERR_STICKY_EN
      ovf_next = err_overflow | ovf;
      unf_next = err_underflow | unf;
`else
      ovf_next = ovf;
      unf_next = unf;
`endif
   end

   // Storage is never cleared; reset only makes old words unreachable.
   always_ff @(posedge clk) begin
      if (!reset && wr_ok)
         mem[wr_ptr] <= Fifo_Data_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         Fifo_data_out <= '0;
         Fifo_valid    <= 1'b0;
         Fifo_empty    <= 1'b1;
         Fifo_full     <= 1'b0;
         almost_empty  <= 1'b1;
         almost_full   <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (rd_ok) begin
            rd_ptr        <= rd_ptr + ADDR_WIDTH'(1);
            Fifo_data_out <= mem[rd_ptr];
         end
         Fifo_valid    <= rd_ok;
         count         <= next_count;
         // Flags track the post-update occupancy so they line up with fill_level.
         Fifo_empty    <= (next_count == '0);
         Fifo_full     <= (next_count == DEPTH);
         almost_empty  <= (next_count <= umbral_vacio);
         almost_full   <= (next_count >= umbral_lleno);
         err_overflow  <= ovf_next;
         err_underflow <= unf_next;
      end
   end

   assign fill_level = count;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: read requests queue their expected word, a monitor
// checks every Fifo_valid strobe; flags are checked after each edge. Honours FIFO_ERR_STICKY_EN.
module tb_fifo_param;

   localparam int VACIO = 2;
   localparam int LLENO = 6;
`ifdef FIFO_ERR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Fifo_Data_in;
   logic       Fifo_wr;
   logic       Fifo_rd;
   logic [3:0] umbral_vacio;
   logic [3:0] umbral_lleno;
   logic [5:0] Fifo_data_out;
   logic       Fifo_valid;
   logic       Fifo_empty;
   logic       Fifo_full;
   logic       almost_empty;
   logic       almost_full;
   logic [3:0] fill_level;
   logic       err_overflow;
   logic       err_underflow;

   int         checks = 0;
   int         errors = 0;
   logic [5:0] expected_q[$];
   bit         seen_ovf = 1'b0;
   bit         seen_unf = 1'b0;
   logic [5:0] exp_word;

   fifo_param dut (
      .clk(clk),
      .reset(reset),
      .Fifo_Data_in(Fifo_Data_in),
      .Fifo_wr(Fifo_wr),
      .Fifo_rd(Fifo_rd),
      .umbral_vacio(umbral_vacio),
      .umbral_lleno(umbral_lleno),
      .Fifo_data_out(Fifo_data_out),
      .Fifo_valid(Fifo_valid),
      .Fifo_empty(Fifo_empty),
      .Fifo_full(Fifo_full),
      .almost_empty(almost_empty),
      .almost_full(almost_full),
      .fill_level(fill_level),
      .err_overflow(err_overflow),
      .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   // Monitor: every read strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (Fifo_valid) begin
         checks++;
         if (expected_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_valid: got data 0x%02h with nothing expected", Fifo_data_out);
         end else begin
            exp_word = expected_q.pop_front();
            if (Fifo_data_out !== exp_word) begin
               errors++;
               $display("[TB] FAIL read_data: got 0x%02h want 0x%02h", Fifo_data_out, exp_word);
            end
         end
      end
   end

   task automatic checkValue(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit wr, input bit rd, input logic [5:0] data, input bit rst);
      Fifo_wr      = wr;
      Fifo_rd      = rd;
      Fifo_Data_in = data;
      reset        = rst;
      @(posedge clk);
      #1;
      Fifo_wr = 1'b0;
      Fifo_rd = 1'b0;
      reset   = 1'b0;
      if (rst) begin
         seen_ovf = 1'b0;
         seen_unf = 1'b0;
      end
   endtask

   // Error pulses passed in are per-edge; sticky builds hold them until reset.
   task automatic checkOutput(input string tag, input int fill, input bit ovf_p, input bit unf_p);
      seen_ovf = seen_ovf | ovf_p;
      seen_unf = seen_unf | unf_p;
      checkValue({tag, ".fill"}, int'(fill_level), fill);
      checkValue({tag, ".empty"}, int'(Fifo_empty), int'(fill == 0));
      checkValue({tag, ".full"}, int'(Fifo_full), int'(fill == 8));
      checkValue({tag, ".aempty"}, int'(almost_empty), int'(fill <= VACIO));
      checkValue({tag, ".afull"}, int'(almost_full), int'(fill >= LLENO));
      checkValue({tag, ".ovf"}, int'(err_overflow), STICKY ? int'(seen_ovf) : int'(ovf_p));
      checkValue({tag, ".unf"}, int'(err_underflow), STICKY ? int'(seen_unf) : int'(unf_p));
   endtask

   task automatic doWrite(input logic [5:0] data);
      applyStimulus(1'b1, 1'b0, data, 1'b0);
   endtask

   task automatic doRead(input logic [5:0] exp);
      expected_q.push_back(exp);
      applyStimulus(1'b0, 1'b1, 6'h00, 1'b0);
   endtask

   task automatic doBoth(input logic [5:0] data, input logic [5:0] exp);
      expected_q.push_back(exp);
      applyStimulus(1'b1, 1'b1, data, 1'b0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput(tag, 0, 1'b0, 1'b0);
      checkValue({tag, ".dout"}, int'(Fifo_data_out), 0);
      checkValue({tag, ".valid"}, int'(Fifo_valid), 0);
   endtask

   initial begin
      reset        = 1'b0;
      Fifo_wr      = 1'b0;
      Fifo_rd      = 1'b0;
      Fifo_Data_in = '0;
      umbral_vacio = 4'(VACIO);
      umbral_lleno = 4'(LLENO);
      @(negedge clk);

      applyStimulus(1'b0, 1'b0, 6'h00, 1'b1);
      checkResetState("reset");

      for (int i = 1; i <= 8; i++) begin
         doWrite(6'(i));
         checkOutput($sformatf("fill%0d", i), i, 1'b0, 1'b0);
      end

      doWrite(6'h3F);
      checkOutput("ovf_write", 8, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 6'h00, 1'b0);
      checkOutput("ovf_after", 8, 1'b0, 1'b0);

      for (int i = 1; i <= 8; i++) begin
         doRead(6'(i));
         checkValue($sformatf("drain%0d.valid", i), int'(Fifo_valid), 1);
         checkOutput($sformatf("drain%0d", i), 8 - i, 1'b0, 1'b0);
      end

      applyStimulus(1'b0, 1'b1, 6'h00, 1'b0);
      checkOutput("rd_empty", 0, 1'b0, 1'b1);
      checkValue("rd_empty.valid", int'(Fifo_valid), 0);
      checkValue("rd_empty.dout", int'(Fifo_data_out), 8);

      applyStimulus(1'b1, 1'b1, 6'h15, 1'b0);
      checkOutput("wrrd_empty", 1, 1'b0, 1'b1);
      checkValue("wrrd_empty.valid", int'(Fifo_valid), 0);
      doRead(6'h15);
      checkOutput("read_15", 0, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) doWrite(6'(8'h20 + i));
      checkOutput("wrap_w5", 5, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) doRead(6'(8'h20 + i));
      checkOutput("wrap_r5", 0, 1'b0, 1'b0);
      doWrite(6'h10);
      doWrite(6'h11);
      for (int i = 0; i < 20; i++) begin
         doBoth(6'(8'h12 + i), 6'(8'h10 + i));
         checkOutput($sformatf("steady%0d", i), 2, 1'b0, 1'b0);
      end
      doRead(6'h24);
      doRead(6'h25);
      checkOutput("steady_drain", 0, 1'b0, 1'b0);

      for (int i = 0; i < 8; i++) doWrite(6'(8'h28 + i));
      checkOutput("full_again", 8, 1'b0, 1'b0);
      doBoth(6'h11, 6'h28);
      checkOutput("full_wrrd", 8, 1'b0, 1'b0);
      checkValue("full_wrrd.valid", int'(Fifo_valid), 1);
      for (int i = 1; i < 8; i++) doRead(6'(8'h28 + i));
      doRead(6'h11);
      checkOutput("full_drain", 0, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) doWrite(6'(8'h01 + i));
      checkOutput("pre_reset", 5, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 6'h3A, 1'b1);
      checkResetState("mid_reset");
      doWrite(6'h0C);
      checkOutput("post_reset_w", 1, 1'b0, 1'b0);
      doRead(6'h0C);
      checkOutput("post_reset_r", 0, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkValue("scoreboard_left", expected_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
